// File: rtl/trace_pkg.sv
// Shared types for the commit-trace recorder: the trace record layout, the
// halt FSM states and the instruction word that counts as a no-op.
package trace_pkg;

    localparam int unsigned TRACE_XLEN   = 32;
    localparam int unsigned TRACE_REG_AW = 5;

    localparam logic [TRACE_XLEN-1:0] NOP_INST = 32'h0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } trace_state_e;

    typedef struct packed {
        logic [TRACE_XLEN-1:0]   pc;
        logic [TRACE_XLEN-1:0]   inst;
        logic                    we;
        logic [TRACE_REG_AW-1:0] waddr;
        logic [TRACE_XLEN-1:0]   wdata;
    } trace_rec_t;

    localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO. A write into a full FIFO is
// accepted when a pop frees the head slot in the same cycle.
module trace_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop_ok;
    logic             wr_en;

    // Extra pointer bit separates the full and empty cases.
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop_ok = pop && !empty;
    assign wr_en  = push && (!full || pop_ok);
    assign rdata  = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/commit_trace_recorder.sv
// Captures retired-instruction records into an on-chip FIFO, stops tracing on
// a run of zero instructions and counts dropped records instead of stalling.
module commit_trace_recorder
    import trace_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HALT_NOPS   = 2,
    parameter bit          WRITES_ONLY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit_valid,
    input  logic [XLEN-1:0]   commit_pc,
    input  logic [XLEN-1:0]   commit_inst,
    input  logic              rf_we,
    input  logic [REG_AW-1:0] rf_waddr,
    input  logic [XLEN-1:0]   rf_wdata,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [XLEN-1:0]   rd_pc,
    output logic [XLEN-1:0]   rd_inst,
    output logic              rd_we,
    output logic [REG_AW-1:0] rd_waddr,
    output logic [XLEN-1:0]   rd_wdata,
    output logic              halted,
    output logic              overflow,
    output logic [31:0]       commit_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned ZW = (HALT_NOPS < 2) ? 1 : $clog2(HALT_NOPS + 1);

    trace_state_e state_q, state_d;
    logic [ZW-1:0] zrun_q, zrun_d;
    logic [31:0]   commit_cnt_q, commit_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          overflow_q, overflow_d;

    logic       active, is_zero, halting, eff_we, recordable;
    logic       push, pop, fifo_full, fifo_empty;
    trace_rec_t rec_in, rec_out;

    assign active     = commit_valid && (state_q == RUN);
    assign is_zero    = (TRACE_XLEN'(commit_inst) == NOP_INST);
    assign halting    = active && is_zero && (zrun_q == ZW'(HALT_NOPS - 1));
    assign eff_we     = rf_we && (rf_waddr != '0);
    assign recordable = active && !halting && (!WRITES_ONLY || eff_we);
    assign pop        = rd_valid && rd_ready;
    assign push       = recordable && (!fifo_full || pop);

    // Writes to r0 are scrubbed so the record reflects architectural effect.
    always_comb begin
        rec_in       = '0;
        rec_in.pc    = TRACE_XLEN'(commit_pc);
        rec_in.inst  = TRACE_XLEN'(commit_inst);
        rec_in.we    = eff_we;
        rec_in.waddr = eff_we ? TRACE_REG_AW'(rf_waddr) : '0;
        rec_in.wdata = eff_we ? TRACE_XLEN'(rf_wdata) : '0;
    end

    always_comb begin
        state_d      = state_q;
        zrun_d       = zrun_q;
        commit_cnt_d = commit_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = overflow_q;
        if (active) begin
            zrun_d = is_zero ? zrun_q + ZW'(1) : '0;
        end
        if (halting) begin
            state_d = HALTED;
        end
        if (push) begin
            commit_cnt_d = commit_cnt_q + 32'd1;
        end else if (recordable) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            zrun_q       <= '0;
            commit_cnt_q <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            zrun_q       <= zrun_d;
            commit_cnt_q <= commit_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    trace_fifo #(
        .WIDTH(TRACE_REC_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .wdata(rec_in),
        .pop  (pop),
        .rdata(rec_out),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign rd_valid   = !fifo_empty;
    assign rd_pc      = XLEN'(rec_out.pc);
    assign rd_inst    = XLEN'(rec_out.inst);
    assign rd_we      = rec_out.we;
    assign rd_waddr   = REG_AW'(rec_out.waddr);
    assign rd_wdata   = XLEN'(rec_out.wdata);
    assign halted     = (state_q == HALTED);
    assign overflow   = overflow_q;
    assign commit_cnt = commit_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_recorder.sv
// Scoreboard bench for commit_trace_recorder: two instances (normal, writes-only)
// with expected records queued at commit time and checked as they are popped.
module tb_commit_trace_recorder;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        c_valid = 1'b0, c_we = 1'b0, rd_ready = 1'b0;
    logic [31:0] c_pc = '0, c_inst = '0, c_wdata = '0;
    logic [4:0]  c_waddr = '0;
    logic        rd_valid, rd_we, halted, overflow;
    logic [31:0] rd_pc, rd_inst, rd_wdata, commit_cnt;
    logic [4:0]  rd_waddr;
    logic [15:0] drop_cnt;

    logic        c2_valid = 1'b0, c2_we = 1'b0, rd2_ready = 1'b1;
    logic [31:0] c2_pc = '0, c2_inst = '0, c2_wdata = '0;
    logic [4:0]  c2_waddr = '0;
    logic        rd2_valid, rd2_we, halted2, overflow2;
    logic [31:0] rd2_pc, rd2_inst, rd2_wdata, commit_cnt2;
    logic [4:0]  rd2_waddr;
    logic [15:0] drop_cnt2;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t exp2_q[$];
    exp_t e, e2;

    always #5 clk = ~clk;

    commit_trace_recorder #(.DEPTH(4), .HALT_NOPS(2), .WRITES_ONLY(1'b0)) dut (
        .clk(clk), .reset(reset), .commit_valid(c_valid), .commit_pc(c_pc),
        .commit_inst(c_inst), .rf_we(c_we), .rf_waddr(c_waddr), .rf_wdata(c_wdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_inst(rd_inst),
        .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .halted(halted),
        .overflow(overflow), .commit_cnt(commit_cnt), .drop_cnt(drop_cnt)
    );

    commit_trace_recorder #(.DEPTH(4), .HALT_NOPS(2), .WRITES_ONLY(1'b1)) dut2 (
        .clk(clk), .reset(reset), .commit_valid(c2_valid), .commit_pc(c2_pc),
        .commit_inst(c2_inst), .rf_we(c2_we), .rf_waddr(c2_waddr), .rf_wdata(c2_wdata),
        .rd_valid(rd2_valid), .rd_ready(rd2_ready), .rd_pc(rd2_pc), .rd_inst(rd2_inst),
        .rd_we(rd2_we), .rd_waddr(rd2_waddr), .rd_wdata(rd2_wdata), .halted(halted2),
        .overflow(overflow2), .commit_cnt(commit_cnt2), .drop_cnt(drop_cnt2)
    );

    function automatic exp_t model_rec(input logic [31:0] pc, input logic [31:0] inst,
                                       input logic we, input logic [4:0] wa,
                                       input logic [31:0] wd);
        exp_t r;
        r.pc    = pc;
        r.inst  = inst;
        r.we    = we && (wa != 5'd0);
        r.waddr = r.we ? wa : 5'd0;
        r.wdata = r.we ? wd : 32'd0;
        return r;
    endfunction

    // Handshakes are sampled at the falling edge, ahead of the edge that pops.
    always @(negedge clk) begin
        if (!reset && rd_valid && rd_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got pc=%h inst=%h, no record expected", rd_pc, rd_inst);
            end else begin
                e = exp_q.pop_front();
                if ({rd_pc, rd_inst, rd_we, rd_waddr, rd_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL pop_record: got pc=%h inst=%h we=%b wa=%0d wd=%h, want pc=%h inst=%h we=%b wa=%0d wd=%h",
                             rd_pc, rd_inst, rd_we, rd_waddr, rd_wdata, e.pc, e.inst, e.we, e.waddr, e.wdata);
                end
            end
        end
        if (!reset && rd2_valid && rd2_ready) begin
            n_tests++;
            if (exp2_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop2_unexpected: got pc=%h wa=%0d, no record expected", rd2_pc, rd2_waddr);
            end else begin
                e2 = exp2_q.pop_front();
                if ({rd2_pc, rd2_inst, rd2_we, rd2_waddr, rd2_wdata} !== e2) begin
                    n_fail++;
                    $display("FAIL pop2_record: got pc=%h we=%b wa=%0d wd=%h, want pc=%h we=%b wa=%0d wd=%h",
                             rd2_pc, rd2_we, rd2_waddr, rd2_wdata, e2.pc, e2.we, e2.waddr, e2.wdata);
                end
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        exp2_q.delete();
    endtask

    task automatic do_commit(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                             input logic [4:0] wa, input logic [31:0] wd, input bit expect_rec);
        c_valid = 1'b1; c_pc = pc; c_inst = inst; c_we = we; c_waddr = wa; c_wdata = wd;
        if (expect_rec) exp_q.push_back(model_rec(pc, inst, we, wa, wd));
        @(posedge clk); #1;
        c_valid = 1'b0;
    endtask

    task automatic do_commit2(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                              input logic [4:0] wa, input logic [31:0] wd, input bit expect_rec);
        c2_valid = 1'b1; c2_pc = pc; c2_inst = inst; c2_we = we; c2_waddr = wa; c2_wdata = wd;
        if (expect_rec) exp2_q.push_back(model_rec(pc, inst, we, wa, wd));
        @(posedge clk); #1;
        c2_valid = 1'b0;
    endtask

    task automatic wait_drain(output int left);
        rd_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || exp2_q.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        repeat (2) begin @(posedge clk); #1; end
        left = exp_q.size() + exp2_q.size();
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({rd_valid, halted, overflow, commit_cnt, drop_cnt, rd_pc, rd_inst, rd_we, rd_waddr, rd_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b h=%b ov=%b cc=%0d dc=%0d pc=%h, want all zero",
                     rd_valid, halted, overflow, commit_cnt, drop_cnt, rd_pc);
        end
    endtask

    task automatic test_basic();
        int left;
        apply_reset();
        rd_ready = 1'b1;
        do_commit(32'h0040_0000, 32'h2008_0001, 1'b1, 5'd8, 32'h1, 1'b1);
        do_commit(32'h0040_0004, 32'h2008_0002, 1'b1, 5'd8, 32'h2, 1'b1);
        do_commit(32'h0040_0008, 32'h2008_0003, 1'b1, 5'd8, 32'h3, 1'b1);
        wait_drain(left);
        n_tests++;
        if (left != 0) begin n_fail++; $display("FAIL basic_drain: %0d records left, want 0", left); end
        n_tests++;
        if (commit_cnt !== 32'd3) begin n_fail++; $display("FAIL basic_commit_cnt: got %0d want 3", commit_cnt); end
        n_tests++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty: rd_valid=%b want 0", rd_valid); end
    endtask

    task automatic test_halt();
        int left;
        apply_reset();
        rd_ready = 1'b1;
        do_commit(32'h100, 32'h0,         1'b0, 5'd0, 32'h0, 1'b1);
        do_commit(32'h104, 32'h2009_0005, 1'b1, 5'd9, 32'h5, 1'b1);
        do_commit(32'h108, 32'h0,         1'b0, 5'd0, 32'h0, 1'b1);
        n_tests++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_early: halted=%b want 0", halted); end
        do_commit(32'h10c, 32'h0,         1'b0, 5'd0, 32'h0, 1'b0);
        n_tests++;
        if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_rise: halted=%b want 1", halted); end
        do_commit(32'h110, 32'h200a_0007, 1'b1, 5'd10, 32'h7, 1'b0);
        do_commit(32'h114, 32'h0,         1'b0, 5'd0, 32'h0, 1'b0);
        wait_drain(left);
        n_tests++;
        if (left != 0) begin n_fail++; $display("FAIL halt_drain: %0d records left, want 0", left); end
        n_tests++;
        if (commit_cnt !== 32'd3 || drop_cnt !== 16'd0 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_ignored: cc=%0d dc=%0d h=%b want cc=3 dc=0 h=1", commit_cnt, drop_cnt, halted);
        end
    endtask

    task automatic test_overflow();
        int left;
        apply_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_commit(32'h200 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b1, 5'(i + 1), 32'(i * 3), i < 4);
        end
        n_tests++;
        if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL ovf_flags: ov=%b dc=%0d want ov=1 dc=2", overflow, drop_cnt);
        end
        n_tests++;
        if (rd_valid !== 1'b1 || rd_pc !== 32'h200) begin
            n_fail++;
            $display("FAIL ovf_head: v=%b pc=%h want v=1 pc=00000200", rd_valid, rd_pc);
        end
        wait_drain(left);
        n_tests++;
        if (left != 0 || commit_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL ovf_drain: left=%0d cc=%0d want left=0 cc=4", left, commit_cnt);
        end
    endtask

    task automatic test_full_push_pop();
        int left;
        apply_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_commit(32'h300 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1'b1, 5'd3, 32'(i), 1'b1);
        end
        rd_ready = 1'b1;
        do_commit(32'h310, 32'h2000_0004, 1'b1, 5'd3, 32'h4, 1'b1);
        wait_drain(left);
        n_tests++;
        if (left != 0 || drop_cnt !== 16'd0 || overflow !== 1'b0 || commit_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL full_pushpop: left=%0d dc=%0d ov=%b cc=%0d want 0/0/0/5",
                     left, drop_cnt, overflow, commit_cnt);
        end
    endtask

    task automatic test_writes_only();
        int left;
        apply_reset();
        do_commit2(32'h400, 32'h2000_0011, 1'b1, 5'd0, 32'hdead, 1'b0);
        do_commit2(32'h404, 32'h2000_0012, 1'b0, 5'd7, 32'hbeef, 1'b0);
        do_commit2(32'h408, 32'h2005_0013, 1'b1, 5'd5, 32'h55,   1'b1);
        wait_drain(left);
        n_tests++;
        if (left != 0 || commit_cnt2 !== 32'd1 || drop_cnt2 !== 16'd0) begin
            n_fail++;
            $display("FAIL writes_only: left=%0d cc=%0d dc=%0d want 0/1/0", left, commit_cnt2, drop_cnt2);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        rd_ready = 1'b0;
        do_commit(32'h500, 32'h2000_0021, 1'b1, 5'd4, 32'h9, 1'b1);
        do_commit(32'h504, 32'h0,         1'b0, 5'd0, 32'h0, 1'b1);
        do_commit(32'h508, 32'h0,         1'b0, 5'd0, 32'h0, 1'b0);
        n_tests++;
        if (halted !== 1'b1 || commit_cnt !== 32'd2 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: h=%b cc=%0d v=%b want h=1 cc=2 v=1", halted, commit_cnt, rd_valid);
        end
        apply_reset();
        n_tests++;
        if ({rd_valid, halted, overflow, commit_cnt, drop_cnt, rd_pc} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_post: v=%b h=%b ov=%b cc=%0d dc=%0d pc=%h want all zero",
                     rd_valid, halted, overflow, commit_cnt, drop_cnt, rd_pc);
        end
        do_commit(32'h600, 32'h2000_0031, 1'b1, 5'd2, 32'h1, 1'b1);
        n_tests++;
        if (halted !== 1'b0 || rd_valid !== 1'b1 || rd_pc !== 32'h600) begin
            n_fail++;
            $display("FAIL rstmid_run: h=%b v=%b pc=%h want h=0 v=1 pc=00000600", halted, rd_valid, rd_pc);
        end
    endtask

    initial begin
        int left;
        test_reset();
        test_basic();
        test_halt();
        test_overflow();
        test_full_push_pop();
        test_writes_only();
        test_reset_mid();
        wait_drain(left);
        n_tests++;
        if (left != 0) begin n_fail++; $display("FAIL final_drain: %0d records left, want 0", left); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_trace_recorder.md
# commit_trace_recorder

- Synthesisable commit-trace capture unit that sits beside the single-cycle CPU core inside `sccomp_dataflow`.
- Each retired instruction's PC, instruction word and register-file write are stored as one record in a parametrised on-chip FIFO.
- A debug host or bench drains the FIFO through a valid/ready port.
- Tracing stops on a configurable run of consecutive all-zero instructions, and overflow is reported rather than stalling the core.

## Interface
Parameters:
- `XLEN`, 32, PC/instruction/data width
- `REG_AW`, 5, register address width
- `DEPTH`, 16, FIFO entries (power of two, ≥2)
- `HALT_NOPS`, 2, consecutive `inst==0` commits that end tracing (≥1)
- `WRITES_ONLY`, 0, 1 = record only commits with an effective register write

Ports:
- `clk` in 1: single clock; all state changes on its rising edge
- `reset` in 1: synchronous, active-high
- `commit_valid` in 1: an instruction retires this cycle
- `commit_pc` in XLEN: PC of the retiring instruction
- `commit_inst` in XLEN: its instruction word
- `rf_we` in 1: register write enable for the retiring instruction
- `rf_waddr` in REG_AW: register write address
- `rf_wdata` in XLEN: register write data
- `rd_valid` out 1: head record available
- `rd_ready` in 1: consumer accepts the head record
- `rd_pc` out XLEN, `rd_inst` out XLEN, `rd_we` out 1, `rd_waddr` out REG_AW, `rd_wdata` out XLEN: head record fields
- `halted` out 1: tracing has stopped
- `overflow` out 1: sticky; at least one record was dropped
- `commit_cnt` out 32: number of records pushed (wraps)
- `drop_cnt` out 16: number of records dropped (saturates at 16'hFFFF)

## Operation
States:
- RUN is the reset state; HALTED is the only other state.
- RUN→HALTED on the commit that brings the consecutive-zero run to `HALT_NOPS`.
- HALTED→RUN only via `reset`.

Zero-instruction run counter:
- Increments on each committed `inst==0`.
- Clears on any committed nonzero instruction.
- Unchanged when `commit_valid=0`.

Recording:
- The halting commit itself is not recorded; earlier zero commits are recorded.
- Effective write: `rd_we = rf_we && rf_waddr!=0`. A write to r0 is recorded with `we=0`, `waddr=0`, `wdata=0`.
- `WRITES_ONLY=1`: commits without an effective write are not pushed. They still update the zero-run counter, so halt detection still works.
- In HALTED, commits are ignored entirely: no push, no counter change, no drop.

Push and pop:
- Push occurs when a commit is recordable and the FIFO is not full, or when it is full and a pop happens in the same cycle (the entry freed that cycle is reused).
- Otherwise the record is dropped: `overflow` set, `drop_cnt`+1.
- The core is never back-pressured.
- Pop occurs when `rd_valid && rd_ready`. `rd_ready` while empty is a no-op.
- Popping continues in HALTED, so the FIFO drains fully after a halt.
- Pointers are `log2(DEPTH)+1` bits wide; the extra bit distinguishes full from empty.

Reset:
- Reset mid-operation discards all FIFO contents and returns to RUN.

## Timing
- Reset values: `rd_valid=0`, `halted=0`, `overflow=0`, `commit_cnt=0`, `drop_cnt=0`, zero-run counter 0, `rd_*` fields 0.
- Latency: a commit pushed at edge N gives `rd_valid=1` after edge N with its fields. The FIFO is first-word fall-through; fields are valid while `rd_valid=1` and stable until popped.
- `halted` rises the cycle after the halting commit's edge.
- Throughput: one push and one pop per cycle. Simultaneous push and pop on a full FIFO leaves it full and drops nothing.
- `commit_cnt` wraps from 32'hFFFFFFFF to 0.

## Structure
- Package `trace_pkg` holds:
  - the record struct (`pc`, `inst`, `we`, `waddr`, `wdata`)
  - the state enum (RUN, HALTED)
  - `NOP_INST = 32'h0`
- One sub-module, `trace_fifo`: a parametrised synchronous FWFT FIFO with push/pop, full/empty flags and a width parameter. The record packs into it.
- Top level contains the halt FSM, recordability logic and counters.

## Test plan
- Reset, then 3 commits (pc 0x00400000/04/08, nonzero inst, `rf_we=1` to r8 with 0x1/0x2/0x3), `rd_ready=1` → 3 records in order with matching fields; `commit_cnt=3`.
- Commits of inst 0, then nonzero, then 0, 0 (`HALT_NOPS=2`) → 3 records (0, nonzero, first 0 of the final pair); `halted=1` after the 4th; later commits ignored.
- `DEPTH=4`, `rd_ready=0`, 6 commits → 4 records kept; `overflow=1`, `drop_cnt=2`. Then `rd_ready=1` pops the first 4 pcs in order.
- Full FIFO, commit with `rd_ready=1` in the same cycle → no drop; newest record appears after the 3 older ones.
- `WRITES_ONLY=1`: commits with a write to r0, no write, and a write to r5 → exactly 1 record (r5).
- `reset` asserted while 2 records are queued and `halted=1` → next cycle `rd_valid=0`, `halted=0`, all counters 0.
